// File: rtl/mux4_1_if.sv
// mux4_1_if: data/select bus for the registered 4:1 mux.
// Signals: x (4 packed DW-bit lanes), s0/s1 (lane index bits),
//   out2 (selected lane), sel_onehot (index decode),
//   sel_changed (index differs from previous capture).
interface mux4_1_if #(
    parameter int DW = 1
);
    logic [4*DW-1:0] x;
    logic            s0;
    logic            s1;
    logic [DW-1:0]   out2;
    logic [3:0]      sel_onehot;
    logic            sel_changed;

    modport master (
        output x, s0, s1,
        input  out2, sel_onehot, sel_changed
    );

    modport slave (
        input  x, s0, s1,
        output out2, sel_onehot, sel_changed
    );
endinterface

// File: rtl/mux4_1.sv
// mux4_1: registered 4:1 lane mux with one-hot and change flags.
// Ports: clk, rst_n (sync, active-low), bus (mux4_1_if.slave):
//   x/s0/s1 sampled each edge; out2, sel_onehot, sel_changed
//   are registered, one cycle after sampling.
module mux4_1 #(
    parameter int DW = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mux4_1_if.slave   bus
);
    logic [1:0]    sel;
    logic [DW-1:0] out_d, out_q;
    logic [3:0]    onehot_d, onehot_q;
    logic          changed_d, changed_q;
    logic [1:0]    prev_d, prev_q;
    logic          hist_d, hist_q;

    assign sel = {bus.s1, bus.s0};

    always_comb begin
        out_d     = '0;
        onehot_d  = 4'b0000;
        changed_d = 1'b0;
        prev_d    = sel;
        hist_d    = 1'b1;
        unique case (sel)
            2'd0: begin
                out_d    = bus.x[0*DW +: DW];
                onehot_d = 4'b0001;
            end
            2'd1: begin
                out_d    = bus.x[1*DW +: DW];
                onehot_d = 4'b0010;
            end
            2'd2: begin
                out_d    = bus.x[2*DW +: DW];
                onehot_d = 4'b0100;
            end
            default: begin
                out_d    = bus.x[3*DW +: DW];
                onehot_d = 4'b1000;
            end
        endcase
        // No history right after reset, so the first capture
        // never reports a change.
        changed_d = hist_q && (sel != prev_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            onehot_q  <= 4'b0000;
            changed_q <= 1'b0;
            prev_q    <= 2'b00;
            hist_q    <= 1'b0;
        end else begin
            out_q     <= out_d;
            onehot_q  <= onehot_d;
            changed_q <= changed_d;
            prev_q    <= prev_d;
            hist_q    <= hist_d;
        end
    end

    assign bus.out2        = out_q;
    assign bus.sel_onehot  = onehot_q;
    assign bus.sel_changed = changed_q;
endmodule

// File: tb/tb_mux4_1.sv
// tb_mux4_1: directed checks of mux4_1 at DW=1 and DW=8.
// Expected values are hand-derived from the applied vectors.
module tb_mux4_1;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mux4_1_if #(.DW(1)) b1 ();
    mux4_1_if #(.DW(8)) b8 ();

    mux4_1 #(.DW(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    mux4_1 #(.DW(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [3:0] xv, input logic [1:0] s);
        b1.x  = xv;
        b1.s1 = s[1];
        b1.s0 = s[0];
    endtask

    task automatic chk1(input string tag, input logic o,
                        input logic [3:0] oh, input logic ch);
        check({tag, ".out2"}, 32'(b1.out2), 32'(o));
        check({tag, ".onehot"}, 32'(b1.sel_onehot), 32'(oh));
        check({tag, ".changed"}, 32'(b1.sel_changed), 32'(ch));
    endtask

    logic [3:0] xv;
    logic [1:0] prev;
    logic [1:0] sv;
    logic [3:0] ohx;
    logic [7:0] lane8 [4];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive1(4'hF, 2'b11);
        b8.x  = 32'hFFFF_FFFF;
        b8.s1 = 1'b1;
        b8.s0 = 1'b1;
        tick();
        tick();
        chk1("reset", 1'b0, 4'b0000, 1'b0);
        check("reset8.out2", 32'(b8.out2), 32'h0);

        // Select-change sequence after reset
        rst_n = 1'b1;
        drive1(4'b0110, 2'b00);
        tick();
        chk1("first00", 1'b0, 4'b0001, 1'b0);
        tick();
        chk1("hold00", 1'b0, 4'b0001, 1'b0);
        drive1(4'b0110, 2'b01);
        tick();
        chk1("sw01", 1'b1, 4'b0010, 1'b1);
        tick();
        chk1("hold01", 1'b1, 4'b0010, 1'b0);
        drive1(4'b0110, 2'b11);
        tick();
        chk1("sw11", 1'b0, 4'b1000, 1'b1);
        drive1(4'b0110, 2'b10);
        tick();
        chk1("sw10", 1'b1, 4'b0100, 1'b1);
        prev = 2'b10;

        // Exhaustive DW=1 sweep
        for (int xi = 0; xi < 16; xi++) begin
            for (int si = 0; si < 4; si++) begin
                xv = 4'(xi);
                sv = 2'(si);
                drive1(xv, sv);
                tick();
                ohx = 4'b0001 << sv;
                chk1($sformatf("sweep x%h s%0d", xv, si),
                     xv[sv], ohx, sv != prev);
                prev = sv;
            end
        end

        // Mid-run reset
        drive1(4'b0110, 2'b10);
        tick();
        chk1("pre_rst", 1'b1, 4'b0100, prev != 2'b10);
        rst_n = 1'b0;
        tick();
        chk1("mid_rst", 1'b0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        drive1(4'b0110, 2'b11);
        tick();
        chk1("post_rst", 1'b0, 4'b1000, 1'b0);
        drive1(4'b0110, 2'b10);
        tick();
        chk1("post_rst2", 1'b1, 4'b0100, 1'b1);

        // DW=8 lane selection
        lane8[0] = 8'hAA;
        lane8[1] = 8'hBB;
        lane8[2] = 8'hCC;
        lane8[3] = 8'hDD;
        b8.x = 32'hDDCC_BBAA;
        for (int si = 0; si < 4; si++) begin
            sv = 2'(si);
            b8.s1 = sv[1];
            b8.s0 = sv[0];
            tick();
            check($sformatf("dw8 s%0d", si),
                  32'(b8.out2), 32'(lane8[si]));
            ohx = 4'b0001 << sv;
            check($sformatf("dw8 oh s%0d", si),
                  32'(b8.sel_onehot), 32'(ohx));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
